// File: rtl/genius_control.sv
// genius_control: round/sequence controller for the Genius memory game.
//
// Plays the stored colour sequence on the LEDs, checks the player's button presses
// against it, and adds one item per round until the player wins or loses. It drives
// the external 0-9 time counter (E_TIME enable, R_TIME reset). That counter's
// end_time pulse is the player-input timeout.
//
// Every output is a register. SEQ_ADDR and ROUND are the item and round counters
// themselves. LED, E_TIME, R_TIME, WIN and LOSE are registered from the current
// state and inputs, so they follow the state by one cycle.
//
// Ports:
//   CLKT      in   system clock, rising edge
//   R         in   synchronous active-high reset
//   START     in   begin/restart game (IDLE, WIN, LOSE only)
//   BTN       in   [3:0] one-hot debounced button pulses
//   SEQ_DATA  in   [1:0] colour code read combinationally from ROM[SEQ_ADDR]
//   end_time  in   timeout pulse from the time counter
//   SEQ_ADDR  out  [ADDR_W-1:0] current item index
//   LED       out  [3:0] one-hot colour display
//   ROUND     out  [ADDR_W-1:0] current round, 0-based
//   E_TIME    out  time counter enable
//   R_TIME    out  time counter reset
//   WIN       out  high while in WIN
//   LOSE      out  high while in LOSE
module genius_control #(
    parameter int unsigned MAX_ROUND  = 16,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned SHOW_TICKS = 8,
    parameter int unsigned GAP_TICKS  = 4
) (
    input  logic              CLKT,
    input  logic              R,
    input  logic              START,
    input  logic [3:0]        BTN,
    input  logic [1:0]        SEQ_DATA,
    input  logic              end_time,
    output logic [ADDR_W-1:0] SEQ_ADDR,
    output logic [3:0]        LED,
    output logic [ADDR_W-1:0] ROUND,
    output logic              E_TIME,
    output logic              R_TIME,
    output logic              WIN,
    output logic              LOSE
);

    localparam int unsigned       TickW     = $clog2(SHOW_TICKS + GAP_TICKS);
    localparam logic [TickW-1:0]  ShowLast  = TickW'(SHOW_TICKS - 1);
    localparam logic [TickW-1:0]  GapLast   = TickW'(GAP_TICKS - 1);
    localparam logic [ADDR_W-1:0] LastRound = ADDR_W'(MAX_ROUND - 1);

    typedef enum logic [2:0] {
        StIdle,
        StShowOn,
        StShowOff,
        StWaitIn,
        StWin,
        StLose
    } state_e;

    state_e            state_q, state_d;
    logic [TickW-1:0]  tick_q, tick_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] round_q, round_d;
    logic [3:0]        led_q, led_d;
    logic              e_time_q, e_time_d;
    logic              r_time_q, r_time_d;
    logic              win_q, win_d;
    logic              lose_q, lose_d;

    logic [3:0] expected;
    logic       press_ok;
    logic       press_any;

    assign expected  = 4'b0001 << SEQ_DATA;
    assign press_ok  = (BTN == expected);
    assign press_any = |BTN;

    always_comb begin
        state_d  = state_q;
        // The tick counter is zero unless a show state is counting in place.
        // As a result it clears on every state entry.
        tick_d   = '0;
        addr_d   = addr_q;
        round_d  = round_q;
        led_d    = 4'b0000;
        e_time_d = 1'b0;
        r_time_d = 1'b1;
        win_d    = 1'b0;
        lose_d   = 1'b0;

        unique case (state_q)
            StIdle, StWin, StLose: begin
                win_d  = (state_q == StWin);
                lose_d = (state_q == StLose);
                if (START) begin
                    round_d = '0;
                    addr_d  = '0;
                    state_d = StShowOn;
                end
            end

            StShowOn: begin
                led_d = expected;
                if (tick_q == ShowLast) begin
                    state_d = StShowOff;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

            StShowOff: begin
                if (tick_q == GapLast) begin
                    if (addr_q == round_q) begin
                        addr_d  = '0;
                        state_d = StWaitIn;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = StShowOn;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

            StWaitIn: begin
                e_time_d = 1'b1;
                r_time_d = 1'b0;
                led_d    = BTN;
                // A correct press takes priority over a coincident timeout.
                if (press_ok) begin
                    r_time_d = 1'b1;
                    if (addr_q < round_q) begin
                        addr_d = addr_q + 1'b1;
                    end else if (round_q == LastRound) begin
                        state_d = StWin;
                    end else begin
                        // ROUND cannot wrap: the last round always exits to WIN above.
                        round_d = round_q + 1'b1;
                        addr_d  = '0;
                        state_d = StShowOn;
                    end
                end else if (press_any || end_time) begin
                    state_d = StLose;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLKT) begin
        if (R) begin
            state_q  <= StIdle;
            tick_q   <= '0;
            addr_q   <= '0;
            round_q  <= '0;
            led_q    <= 4'b0000;
            e_time_q <= 1'b0;
            r_time_q <= 1'b1;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            addr_q   <= addr_d;
            round_q  <= round_d;
            led_q    <= led_d;
            e_time_q <= e_time_d;
            r_time_q <= r_time_d;
            win_q    <= win_d;
            lose_q   <= lose_d;
        end
    end

    assign SEQ_ADDR = addr_q;
    assign ROUND    = round_q;
    assign LED      = led_q;
    assign E_TIME   = e_time_q;
    assign R_TIME   = r_time_q;
    assign WIN      = win_q;
    assign LOSE     = lose_q;

endmodule

// File: tb/tb_genius_control.sv
// Testbench for genius_control. The bench plays whole games against a randomised
// colour ROM. Each game can end in a win, a wrong colour, a multi-bit press or a
// timeout. Expected LED and time-counter traces come from the game rules: each item
// is shown for 8 lit cycles and then 4 dark cycles, and the outputs appear one
// cycle after the decision that produces them.
module tb_genius_control;

    localparam int unsigned MaxRound  = 3;
    localparam int unsigned AddrW     = 4;
    localparam int unsigned ShowTicks = 8;
    localparam int unsigned GapTicks  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [3:0]       btn;
    logic             end_time;
    logic [1:0]       seq_data;
    logic [AddrW-1:0] seq_addr;
    logic [3:0]       led;
    logic [AddrW-1:0] round;
    logic             e_time;
    logic             r_time;
    logic             win;
    logic             lose;

    logic [1:0] rom [16];

    int n_checks = 0;
    int n_fail   = 0;

    assign seq_data = rom[seq_addr];

    always #5 clk = ~clk;

    genius_control #(
        .MAX_ROUND (MaxRound),
        .ADDR_W    (AddrW),
        .SHOW_TICKS(ShowTicks),
        .GAP_TICKS (GapTicks)
    ) u_dut (
        .CLKT    (clk),
        .R       (rst),
        .START   (start),
        .BTN     (btn),
        .SEQ_DATA(seq_data),
        .end_time(end_time),
        .SEQ_ADDR(seq_addr),
        .LED     (led),
        .ROUND   (round),
        .E_TIME  (e_time),
        .R_TIME  (r_time),
        .WIN     (win),
        .LOSE    (lose)
    );

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_rom();
        for (int i = 0; i < 16; i++) rom[i] = 2'($urandom_range(3, 0));
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_led"},   32'(led),      32'h0);
        check_val({tag, "_etime"}, 32'(e_time),   32'h0);
        check_val({tag, "_rtime"}, 32'(r_time),   32'h1);
        check_val({tag, "_win"},   32'(win),      32'h0);
        check_val({tag, "_lose"},  32'(lose),     32'h0);
        check_val({tag, "_round"}, 32'(round),    32'h0);
        check_val({tag, "_addr"},  32'(seq_addr), 32'h0);
    endtask

    // Playback of round r: items 0..r, each lit then dark, then input is enabled.
    // START and BTN are driven randomly throughout, and the DUT must ignore both.
    task automatic expect_playback(input int r);
        for (int i = 0; i <= r; i++) begin
            for (int t = 0; t < int'(ShowTicks); t++) begin
                btn   = 4'($urandom_range(15, 0));
                start = 1'($urandom_range(1, 0));
                tick();
                check_val("show_led",   32'(led),      32'(onehot(rom[i])));
                check_val("show_addr",  32'(seq_addr), 32'(i));
                check_val("show_etime", 32'(e_time),   32'h0);
                check_val("show_rtime", 32'(r_time),   32'h1);
                check_val("show_flags", 32'({win, lose}), 32'h0);
            end
            for (int t = 0; t < int'(GapTicks); t++) begin
                btn   = 4'($urandom_range(15, 0));
                start = 1'($urandom_range(1, 0));
                tick();
                check_val("gap_led",   32'(led),    32'h0);
                check_val("gap_etime", 32'(e_time), 32'h0);
            end
        end
        btn   = 4'b0000;
        start = 1'b0;
        tick();
        check_val("in_etime", 32'(e_time),   32'h1);
        check_val("in_rtime", 32'(r_time),   32'h0);
        check_val("in_addr",  32'(seq_addr), 32'h0);
        check_val("in_round", 32'(round),    32'(r));
        check_val("in_led",   32'(led),      32'h0);
    endtask

    // kind: 0 play to win, 1 wrong colour, 2 multi-bit press, 3 timeout.
    task automatic play_game(input int fail_round, input int fail_idx, input int kind);
        logic [3:0] b;
        int         waits;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("start_round", 32'(round),    32'h0);
        check_val("start_addr",  32'(seq_addr), 32'h0);
        for (int r = 0; r < int'(MaxRound); r++) begin
            expect_playback(r);
            for (int idx = 0; idx <= r; idx++) begin
                waits = $urandom_range(2, 0);
                for (int w = 0; w < waits; w++) begin
                    start = 1'($urandom_range(1, 0));
                    tick();
                    start = 1'b0;
                    check_val("wait_etime", 32'(e_time), 32'h1);
                    check_val("wait_rtime", 32'(r_time), 32'h0);
                    check_val("wait_led",   32'(led),    32'h0);
                    check_val("wait_lose",  32'(lose),   32'h0);
                end
                if (kind != 0 && r == fail_round && idx == fail_idx) begin
                    if (kind == 1) begin
                        b = onehot(rom[idx] + 2'($urandom_range(3, 1)));
                    end else if (kind == 2) begin
                        b = 4'($urandom_range(15, 0));
                        if ($countones(b) < 2) b = 4'b0011;
                    end else begin
                        b = 4'b0000;
                        end_time = 1'b1;
                    end
                    btn = b;
                    tick();
                    btn      = 4'b0000;
                    end_time = 1'b0;
                    check_val("miss_led", 32'(led), 32'(b));
                    tick();
                    check_val("lose_flag",  32'(lose),   32'h1);
                    check_val("lose_win",   32'(win),    32'h0);
                    check_val("lose_etime", 32'(e_time), 32'h0);
                    check_val("lose_rtime", 32'(r_time), 32'h1);
                    check_val("lose_led",   32'(led),    32'h0);
                    check_val("lose_round", 32'(round),  32'(r));
                    btn = 4'($urandom_range(15, 1));
                    tick();
                    btn = 4'b0000;
                    check_val("lose_hold", 32'(lose), 32'h1);
                    check_val("lose_ign",  32'(led),  32'h0);
                    return;
                end
                b        = onehot(rom[idx]);
                btn      = b;
                end_time = 1'($urandom_range(1, 0));
                tick();
                btn      = 4'b0000;
                end_time = 1'b0;
                check_val("hit_rtime", 32'(r_time), 32'h1);
                check_val("hit_led",   32'(led),    32'(b));
                check_val("hit_etime", 32'(e_time), 32'h1);
                if (idx < r) begin
                    check_val("hit_addr",  32'(seq_addr), 32'(idx + 1));
                    check_val("hit_round", 32'(round),    32'(r));
                end else if (r == int'(MaxRound) - 1) begin
                    tick();
                    check_val("win_flag",  32'(win),    32'h1);
                    check_val("win_lose",  32'(lose),   32'h0);
                    check_val("win_etime", 32'(e_time), 32'h0);
                    check_val("win_rtime", 32'(r_time), 32'h1);
                    check_val("win_led",   32'(led),    32'h0);
                    check_val("win_round", 32'(round),  32'(MaxRound - 1));
                    btn = 4'($urandom_range(15, 1));
                    tick();
                    btn = 4'b0000;
                    check_val("win_hold", 32'(win), 32'h1);
                    return;
                end else begin
                    check_val("next_round", 32'(round),    32'(r + 1));
                    check_val("next_addr",  32'(seq_addr), 32'h0);
                end
            end
        end
    endtask

    initial begin
        int fr;
        rst      = 1'b1;
        start    = 1'b0;
        btn      = 4'b0000;
        end_time = 1'b0;
        randomize_rom();
        tick();
        tick();
        rst = 1'b0;
        check_reset("reset");

        // IDLE ignores buttons and keeps the timer in reset.
        btn = 4'b0100;
        tick();
        btn = 4'b0000;
        check_val("idle_led",   32'(led),    32'h0);
        check_val("idle_rtime", 32'(r_time), 32'h1);

        // Directed games.
        rom[0] = 2'd2;
        play_game(-1, 0, 0);
        randomize_rom();
        rom[0] = 2'd3;
        play_game(0, 0, 1);
        play_game(1, 1, 3);
        play_game(2, 0, 2);

        // Reset during SHOW_ON.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("rst_show");

        // Reset during WAIT_IN overrides a coincident correct press.
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_playback(0);
        rst = 1'b1;
        btn = onehot(rom[0]);
        tick();
        rst = 1'b0;
        btn = 4'b0000;
        check_reset("rst_wait");

        // Random games.
        for (int g = 0; g < 10; g++) begin
            randomize_rom();
            fr = $urandom_range(MaxRound - 1, 0);
            play_game(fr, $urandom_range(fr, 0), $urandom_range(3, 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
